// File: rtl/launch_sequencer_if.sv
// rtl/launch_sequencer_if.sv - host/core-side bundle for the kernel launch sequencer
//
// Groups the launch request, per-core thread totals, per-core block
// dispatch controls and the completion flags.
//   master : host/core side (drives start, thread_count, core_done)
//   slave  : sequencer side (drives core_reset, core_start, core_block_id,
//            core_thread_count, done)
interface launch_sequencer_if #(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4
);
    localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;

    logic                           start;
    logic [NUM_CORES-1:0][7:0]      thread_count;
    logic [NUM_CORES-1:0]           core_reset;
    logic [NUM_CORES-1:0]           core_start;
    logic [NUM_CORES-1:0][7:0]      core_block_id;
    logic [NUM_CORES-1:0][TCW-1:0]  core_thread_count;
    logic [NUM_CORES-1:0]           core_done;
    logic                           done;

    modport master (
        output start, thread_count, core_done,
        input  core_reset, core_start, core_block_id, core_thread_count, done
    );

    modport slave (
        input  start, thread_count, core_done,
        output core_reset, core_start, core_block_id, core_thread_count, done
    );
endinterface

// File: rtl/launch_sequencer.sv
// rtl/launch_sequencer.sv - per-core block dispatcher for a kernel launch
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; aborts any kernel in flight
//   bus   : launch_sequencer_if.slave
//           start             level launch request from host
//           thread_count      per-core thread totals, captured at launch
//           core_reset        per-core one-cycle pulse ahead of each block
//           core_start        per-core run level while a block executes
//           core_block_id     per-core local index of the current block
//           core_thread_count threads active in the current block
//           core_done         per-core block-complete level (seen in RUN only)
//           done              registered kernel-complete flag
module launch_sequencer #(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    launch_sequencer_if.slave     bus
);
    localparam int LOG_TPB = $clog2(THREADS_PER_BLOCK);
    localparam int TCW     = LOG_TPB + 1;

    typedef enum logic [1:0] {IDLE, RESET, RUN, FIN} state_t;

    state_t     state_q [NUM_CORES];
    state_t     state_d [NUM_CORES];
    logic [7:0] snap_q  [NUM_CORES];
    logic [7:0] disp_q  [NUM_CORES];
    logic       done_q;

    logic       all_idle;
    logic       all_fin;
    logic       launch;
    logic       release_cores;

    // ceil(threads / THREADS_PER_BLOCK); the 9-bit sum keeps 255 from wrapping.
    function automatic logic [7:0] blocks_of(input logic [7:0] threads);
        logic [8:0] sum;
        sum = {1'b0, threads} + 9'(THREADS_PER_BLOCK - 1);
        return 8'(sum >> LOG_TPB);
    endfunction

    always_comb begin
        all_idle = 1'b1;
        all_fin  = 1'b1;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (state_q[i] != IDLE) all_idle = 1'b0;
            if (state_q[i] != FIN)  all_fin  = 1'b0;
        end
        launch        = bus.start && !done_q && all_idle;
        release_cores = done_q && !bus.start;
    end

    // Next-state logic: each core advances on its own; only the launch and
    // the final release are shared events.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                IDLE: begin
                    if (launch)
                        state_d[i] = (blocks_of(bus.thread_count[i]) != 8'd0) ? RESET : FIN;
                end
                RESET: state_d[i] = RUN;
                RUN: begin
                    if (bus.core_done[i])
                        state_d[i] = (({1'b0, disp_q[i]} + 9'd1) < {1'b0, blocks_of(snap_q[i])})
                                     ? RESET : FIN;
                end
                FIN: begin
                    if (release_cores) state_d[i] = IDLE;
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // Per-core outputs decode the registered state; block id and thread count
    // are only presented while a block is being set up or running.
    always_comb begin
        logic [15:0] rem;
        logic        active;
        bus.core_reset        = '0;
        bus.core_start        = '0;
        bus.core_block_id     = '0;
        bus.core_thread_count = '0;
        bus.done              = done_q;
        for (int i = 0; i < NUM_CORES; i++) begin
            rem    = {8'd0, snap_q[i]} - ({8'd0, disp_q[i]} << LOG_TPB);
            active = (state_q[i] == RESET) || (state_q[i] == RUN);
            bus.core_reset[i] = (state_q[i] == RESET);
            bus.core_start[i] = (state_q[i] == RUN);
            if (active) begin
                bus.core_block_id[i]     = disp_q[i];
                bus.core_thread_count[i] = (rem >= 16'(THREADS_PER_BLOCK))
                                           ? TCW'(THREADS_PER_BLOCK) : rem[TCW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                state_q[i] <= IDLE;
                snap_q[i]  <= 8'd0;
                disp_q[i]  <= 8'd0;
            end
            done_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                state_q[i] <= state_d[i];
                if (launch) begin
                    snap_q[i] <= bus.thread_count[i];
                    disp_q[i] <= 8'd0;
                end else if (state_q[i] == RUN && bus.core_done[i]) begin
                    disp_q[i] <= disp_q[i] + 8'd1;
                end
            end
            if (release_cores)
                done_q <= 1'b0;
            else if (all_fin)
                done_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_launch_sequencer.sv
// tb/tb_launch_sequencer.sv - directed bench for launch_sequencer
module tb_launch_sequencer;
    logic clk = 1'b0;
    logic reset;

    launch_sequencer_if #(.NUM_CORES(2), .THREADS_PER_BLOCK(4)) bus ();

    launch_sequencer #(.NUM_CORES(2), .THREADS_PER_BLOCK(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int id_q0[$], tc_q0[$], id_q1[$], tc_q1[$];
    int start_seen [2];
    int done_cyc;
    int last_ack;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches a kernel and acts as both cores: each core raises core_done
    // after lat cycles of core_start. Logs every core_reset pulse.
    task automatic run_kernel(input logic [7:0] t0, input logic [7:0] t1,
                              input logic [7:0] alt0, input logic [7:0] alt1,
                              input int lat0, input int lat1);
        int cnt [2];
        int lat [2];
        int cyc;
        id_q0.delete(); tc_q0.delete(); id_q1.delete(); tc_q1.delete();
        start_seen = '{0, 0};
        cnt = '{0, 0};
        lat[0] = lat0;
        lat[1] = lat1;
        done_cyc = -1;
        last_ack = -1;
        bus.thread_count[0] = t0;
        bus.thread_count[1] = t1;
        bus.core_done = 2'b00;
        bus.start = 1'b1;
        cyc = 0;
        while (cyc < 2000 && done_cyc < 0) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                bus.thread_count[0] = alt0;
                bus.thread_count[1] = alt1;
            end
            for (int c = 0; c < 2; c++) begin
                if (bus.core_reset[c]) begin
                    if (c == 0) begin
                        id_q0.push_back(int'(bus.core_block_id[0]));
                        tc_q0.push_back(int'(bus.core_thread_count[0]));
                    end else begin
                        id_q1.push_back(int'(bus.core_block_id[1]));
                        tc_q1.push_back(int'(bus.core_thread_count[1]));
                    end
                end
                if (bus.core_start[c]) begin
                    start_seen[c]++;
                    cnt[c]++;
                    if (cnt[c] == lat[c]) begin
                        bus.core_done[c] = 1'b1;
                        last_ack = cyc;
                    end else begin
                        bus.core_done[c] = 1'b0;
                    end
                end else begin
                    cnt[c] = 0;
                    bus.core_done[c] = 1'b0;
                end
            end
            if (bus.done) done_cyc = cyc;
        end
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL kernel_timeout: done never rose within 2000 cycles");
        end
    endtask

    task automatic finish_kernel();
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL release_done: got %0b expected 0", bus.done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.thread_count = '0;
        bus.core_done = 2'b00;
        tick();
        tick();
        checks++;
        if (bus.core_reset !== 2'b00 || bus.core_start !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl: core_reset=%b core_start=%b expected 00 00", bus.core_reset, bus.core_start);
        end
        checks++;
        if (bus.core_block_id !== 16'h0 || bus.core_thread_count !== 6'h0) begin
            errors++;
            $display("FAIL reset_data: block_id=%h thread_count=%h expected 0 0", bus.core_block_id, bus.core_thread_count);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %0b expected 0", bus.done);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int e_id0[2] = '{0, 1};
        int e_tc0[2] = '{4, 4};
        int e_id1[2] = '{0, 1};
        int e_tc1[2] = '{4, 1};
        run_kernel(8'd8, 8'd5, 8'd8, 8'd5, 2, 3);
        checks++;
        if (id_q0.size() != 2 || id_q1.size() != 2) begin
            errors++;
            $display("FAIL basic_blocks: core0=%0d core1=%0d expected 2 2", id_q0.size(), id_q1.size());
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (id_q0[k] != e_id0[k] || tc_q0[k] != e_tc0[k]) begin
                errors++;
                $display("FAIL basic_core0_blk%0d: id=%0d tc=%0d expected %0d %0d", k, id_q0[k], tc_q0[k], e_id0[k], e_tc0[k]);
            end
            checks++;
            if (id_q1[k] != e_id1[k] || tc_q1[k] != e_tc1[k]) begin
                errors++;
                $display("FAIL basic_core1_blk%0d: id=%0d tc=%0d expected %0d %0d", k, id_q1[k], tc_q1[k], e_id1[k], e_tc1[k]);
            end
        end
        checks++;
        if (done_cyc - last_ack != 2) begin
            errors++;
            $display("FAIL basic_done_latency: got %0d expected 2", done_cyc - last_ack);
        end
        finish_kernel();
    endtask

    task automatic test_zero_threads();
        run_kernel(8'd0, 8'd3, 8'd0, 8'd3, 1, 2);
        checks++;
        if (id_q0.size() != 0 || start_seen[0] != 0) begin
            errors++;
            $display("FAIL zero_core0: resets=%0d start_cycles=%0d expected 0 0", id_q0.size(), start_seen[0]);
        end
        checks++;
        if (id_q1.size() != 1 || id_q1[0] != 0 || tc_q1[0] != 3) begin
            errors++;
            $display("FAIL zero_core1: n=%0d id=%0d tc=%0d expected 1 0 3", id_q1.size(), id_q1[0], tc_q1[0]);
        end
        checks++;
        if (done_cyc - last_ack != 2) begin
            errors++;
            $display("FAIL zero_done_latency: got %0d expected 2", done_cyc - last_ack);
        end
        finish_kernel();
    endtask

    task automatic test_snapshot();
        run_kernel(8'd8, 8'd8, 8'd1, 8'd1, 2, 2);
        checks++;
        if (id_q0.size() != 2 || id_q0[1] != 1 || tc_q0[0] != 4 || tc_q0[1] != 4) begin
            errors++;
            $display("FAIL snapshot_core0: n=%0d id1=%0d tc=%0d,%0d expected 2 1 4,4", id_q0.size(), id_q0[1], tc_q0[0], tc_q0[1]);
        end
        checks++;
        if (id_q1.size() != 2 || id_q1[1] != 1 || tc_q1[0] != 4 || tc_q1[1] != 4) begin
            errors++;
            $display("FAIL snapshot_core1: n=%0d id1=%0d tc=%0d,%0d expected 2 1 4,4", id_q1.size(), id_q1[1], tc_q1[0], tc_q1[1]);
        end
        finish_kernel();
    endtask

    task automatic test_max_threads();
        run_kernel(8'd255, 8'd1, 8'd255, 8'd1, 1, 1);
        checks++;
        if (id_q0.size() != 64) begin
            errors++;
            $display("FAIL max_blocks: got %0d expected 64", id_q0.size());
        end
        checks++;
        if (id_q0[62] != 62 || tc_q0[62] != 4 || id_q0[63] != 63 || tc_q0[63] != 3) begin
            errors++;
            $display("FAIL max_tail: %0d/%0d %0d/%0d expected 62/4 63/3", id_q0[62], tc_q0[62], id_q0[63], tc_q0[63]);
        end
        checks++;
        if (id_q1.size() != 1 || tc_q1[0] != 1) begin
            errors++;
            $display("FAIL max_core1: n=%0d tc=%0d expected 1 1", id_q1.size(), tc_q1[0]);
        end
        finish_kernel();
    endtask

    task automatic test_mid_reset();
        int n;
        bus.thread_count[0] = 8'd8;
        bus.thread_count[1] = 8'd5;
        bus.core_done = 2'b00;
        bus.start = 1'b1;
        n = 0;
        while (n < 20 && bus.core_start[0] !== 1'b1) begin
            tick();
            n++;
        end
        checks++;
        if (bus.core_start[0] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_run: core_start0=%0b expected 1", bus.core_start[0]);
        end
        reset = 1'b1;
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.core_reset !== 2'b00 || bus.core_start !== 2'b00 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ctrl: core_reset=%b core_start=%b done=%b expected 00 00 0", bus.core_reset, bus.core_start, bus.done);
        end
        checks++;
        if (bus.core_block_id !== 16'h0 || bus.core_thread_count !== 6'h0) begin
            errors++;
            $display("FAIL midreset_data: block_id=%h thread_count=%h expected 0 0", bus.core_block_id, bus.core_thread_count);
        end
        reset = 1'b0;
        tick();
        run_kernel(8'd8, 8'd5, 8'd8, 8'd5, 1, 1);
        checks++;
        if (id_q0.size() != 2 || id_q0[0] != 0 || tc_q0[0] != 4 || id_q1.size() != 2 || tc_q1[1] != 1) begin
            errors++;
            $display("FAIL midreset_relaunch: n0=%0d id0=%0d tc0=%0d n1=%0d tc1_last=%0d expected 2 0 4 2 1",
                     id_q0.size(), id_q0[0], tc_q0[0], id_q1.size(), tc_q1[1]);
        end
        finish_kernel();
    endtask

    task automatic test_done_hold();
        run_kernel(8'd4, 8'd4, 8'd4, 8'd4, 1, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (bus.done !== 1'b1 || bus.core_reset !== 2'b00 || bus.core_start !== 2'b00) begin
                errors++;
                $display("FAIL hold_cycle%0d: done=%b core_reset=%b core_start=%b expected 1 00 00", k, bus.done, bus.core_reset, bus.core_start);
            end
        end
        finish_kernel();
        run_kernel(8'd4, 8'd2, 8'd4, 8'd2, 1, 1);
        checks++;
        if (id_q0.size() != 1 || tc_q0[0] != 4 || id_q1.size() != 1 || tc_q1[0] != 2) begin
            errors++;
            $display("FAIL hold_relaunch: n0=%0d tc0=%0d n1=%0d tc1=%0d expected 1 4 1 2", id_q0.size(), tc_q0[0], id_q1.size(), tc_q1[0]);
        end
        finish_kernel();
    endtask

    task automatic test_done_in_reset();
        bus.thread_count[0] = 8'd8;
        bus.thread_count[1] = 8'd0;
        bus.core_done = 2'b00;
        bus.start = 1'b1;
        tick();
        checks++;
        if (bus.core_reset[0] !== 1'b1 || bus.core_block_id[0] !== 8'd0) begin
            errors++;
            $display("FAIL rstdone_pulse0: core_reset=%b id=%0d expected 1 0", bus.core_reset[0], bus.core_block_id[0]);
        end
        bus.core_done[0] = 1'b1;
        tick();
        checks++;
        if (bus.core_start[0] !== 1'b1 || bus.core_reset[0] !== 1'b0 || bus.core_block_id[0] !== 8'd0) begin
            errors++;
            $display("FAIL rstdone_run0: start=%b reset=%b id=%0d expected 1 0 0", bus.core_start[0], bus.core_reset[0], bus.core_block_id[0]);
        end
        tick();
        checks++;
        if (bus.core_reset[0] !== 1'b1 || bus.core_block_id[0] !== 8'd1 || bus.core_thread_count[0] !== 3'd4) begin
            errors++;
            $display("FAIL rstdone_pulse1: reset=%b id=%0d tc=%0d expected 1 1 4", bus.core_reset[0], bus.core_block_id[0], bus.core_thread_count[0]);
        end
        bus.core_done[0] = 1'b0;
        tick();
        bus.core_done[0] = 1'b1;
        tick();
        bus.core_done[0] = 1'b0;
        checks++;
        if (bus.core_start[0] !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL rstdone_fin: start=%b done=%b expected 0 0", bus.core_start[0], bus.done);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL rstdone_done: got %b expected 1", bus.done);
        end
        finish_kernel();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.thread_count = '0;
        bus.core_done = 2'b00;
        test_reset();
        test_basic();
        test_zero_threads();
        test_snapshot();
        test_max_threads();
        test_mid_reset();
        test_done_hold();
        test_done_in_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
